// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle divide
// stall and saturating stall/flush counters for the 5-stage RV32 core.
module hazard_stall_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int DIV_LATENCY    = 4,
   parameter int BR_FLUSH_DEPTH = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] inst_mem,
   input  logic [DATA_WIDTH-1:0] inst_ex,
   input  logic [1:0]            fw_detected,
   input  logic                  br_detected,
   input  logic [1:0]            br_result,
   output logic                  pc_fetch_en,
   output logic                  fe_de_reg_en,
   output logic                  de_ex_reg_en,
   output logic                  fe_de_reg_rst,
   output logic                  de_ex_reg_rst,
   output logic                  ex_mem_reg_rst,
   output logic                  stall_detected,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [CNT_WIDTH-1:0]  flush_cnt
);

   typedef enum logic [1:0] {RUN, DIV_STALL, DIV_RELEASE} state_t;

   localparam int DCW      = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
   // The detect cycle in RUN is the first stall cycle, so DIV_STALL covers
   // DIV_LATENCY-2 cycles and counts down from DIV_LATENCY-3 to 0.
   localparam int DIV_LOAD = (DIV_LATENCY > 3) ? DIV_LATENCY - 3 : 0;

   state_t               state_q, state_d;
   logic [DCW-1:0]       div_cnt_q, div_cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   logic load_mem, div_ex, load_use, redirect;
   logic stall, flush;

   assign load_mem = (inst_mem[6:2] == 5'b00000);
   assign div_ex   = (inst_ex[6:0] == 7'b0110011) & (inst_ex[31:25] == 7'b0000001) & inst_ex[14];
   assign load_use = load_mem & (fw_detected == 2'b10);
   assign redirect = br_detected & (br_result != 2'b01);

   logic unused_inst_bits;
   assign unused_inst_bits = ^{inst_mem[DATA_WIDTH-1:7], inst_mem[1:0],
                               inst_ex[24:15], inst_ex[13:7]};

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      stall     = 1'b0;
      flush     = 1'b0;
      case (state_q)
         RUN: begin
            if (div_ex && (DIV_LATENCY > 1)) begin
               stall     = 1'b1;
               div_cnt_d = DCW'(DIV_LOAD);
               state_d   = (DIV_LATENCY > 2) ? DIV_STALL : DIV_RELEASE;
            end else if (load_use) begin
               stall = 1'b1;
            end else if (redirect) begin
               flush = 1'b1;
            end
         end
         DIV_STALL: begin
            stall = 1'b1;
            if (div_cnt_q == '0) state_d = DIV_RELEASE;
            else                 div_cnt_d = div_cnt_q - 1'b1;
         end
         DIV_RELEASE: begin
            if (load_use)      stall = 1'b1;
            else if (redirect) flush = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (!rst_n) begin
         stall = 1'b0;
         flush = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= RUN;
         div_cnt_q   <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_fetch_en    = ~stall;
   assign fe_de_reg_en   = ~stall;
   assign de_ex_reg_en   = ~stall;
   assign ex_mem_reg_rst = stall;
   assign stall_detected = stall;
   assign de_ex_reg_rst  = flush;
   assign fe_de_reg_rst  = flush & (BR_FLUSH_DEPTH == 2);
   assign stall_cnt      = stall_cnt_q;
   assign flush_cnt      = flush_cnt_q;

endmodule
